// File: rtl/bram_port_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bram_port_ctrl                                               |
// | Description : Burst controller for a single-port registered BRAM.          |
// |               Accepts read/write burst commands, streams write data into   |
// |               the BRAM and streams read data out through a 4-entry FIFO    |
// |               guarded by a credit rule (fifo_count + inflight < 4).        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, rst_n                     clock, asynchronous active-low reset      |
// |   cmd_valid/ready/wr/addr/len    burst command (len = beats - 1)           |
// |   wr_data/valid/ready            write data stream                         |
// |   rd_data/valid/ready            read data stream                          |
// |   busy                           controller not idle                       |
// |   mem_addr/din/we, mem_dout      BRAM port (read data one cycle later)     |
// +----------------------------------------------------------------------------+
// | Configuration                                                              |
// |   BRAM_PORT_CTRL_ADDR_HOLD_EN : when defined, mem_addr/mem_din hold their  |
// |   last values on cycles with no access; otherwise they return to 0.        |
// +----------------------------------------------------------------------------+
module bram_port_ctrl #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout
);

  localparam logic [1:0]  c_IDLE  = 2'd0;
  localparam logic [1:0]  c_WRITE = 2'd1;
  localparam logic [1:0]  c_READ  = 2'd2;
  localparam logic [1:0]  c_DRAIN = 2'd3;
  localparam logic [AW:0] c_ONE   = {{AW{1'b0}}, 1'b1};

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic [AW-1:0] r_addr;
  // Beats still to write (WRITE) or addresses still to issue (READ).
  // One bit wider than AW so a full-memory burst of 2^AW beats fits.
  logic [AW:0]   r_remain;
  logic          r_ready_en;
  // Read pipeline: pend1 = address on the BRAM port this cycle,
  // pend2 = BRAM output holds the data this cycle (pushed at the next edge).
  logic          r_pend1;
  logic          r_pend2;
  logic [DW-1:0] r_fifo [0:3];
  logic [1:0]    r_wr_ptr;
  logic [1:0]    r_rd_ptr;
  logic [2:0]    r_fifo_cnt;

  logic          w_accept;
  logic          w_wr_beat;
  logic          w_rd_issue;
  logic          w_credit;
  logic          w_push;
  logic          w_pop;
  logic [2:0]    w_inflight;
  logic [AW-1:0] w_issue_addr;

  assign w_inflight = {2'b00, r_pend1} + {2'b00, r_pend2};
  // Counting in-flight reads against the FIFO space guarantees no push
  // ever meets a full FIFO.
  assign w_credit   = (r_fifo_cnt + w_inflight) < 3'd4;
  assign w_accept   = cmd_valid & cmd_ready;
  assign w_wr_beat  = wr_valid & wr_ready;
  assign w_push     = r_pend2;
  assign w_pop      = rd_valid & rd_ready;
  assign rd_valid   = (r_fifo_cnt != 3'd0);
  assign rd_data    = r_fifo[r_rd_ptr];
  assign busy       = (r_state != c_IDLE);
  // The first read address goes out on the accepting edge so that data
  // reaches rd_valid three cycles after the command.
  assign w_issue_addr = (r_state == c_IDLE) ? cmd_addr : r_addr;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_accept) begin
          if (cmd_wr) begin
            w_next_state = c_WRITE;
          end else if (w_rd_issue && (cmd_len == '0)) begin
            w_next_state = c_DRAIN;
          end else begin
            w_next_state = c_READ;
          end
        end
      end
      c_WRITE: begin
        if (w_wr_beat && (r_remain == c_ONE)) begin
          w_next_state = c_IDLE;
        end
      end
      c_READ: begin
        if (w_rd_issue && (r_remain == c_ONE)) begin
          w_next_state = c_DRAIN;
        end
      end
      default: begin
        if (w_inflight == 3'd0) begin
          w_next_state = c_IDLE;
        end
      end
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    w_rd_issue = 1'b0;
    case (r_state)
      c_IDLE: begin
        // r_ready_en keeps cmd_ready low until the first edge after reset.
        cmd_ready  = r_ready_en;
        w_rd_issue = cmd_valid & r_ready_en & ~cmd_wr & w_credit;
      end
      c_WRITE: wr_ready   = 1'b1;
      c_READ:  w_rd_issue = w_credit;
      default: ;
    endcase
  end

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready_en <= 1'b0;
      r_addr     <= '0;
      r_remain   <= '0;
      r_pend1    <= 1'b0;
      r_pend2    <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      r_pend1    <= w_rd_issue;
      r_pend2    <= r_pend1;
      if (w_accept) begin
        r_addr   <= cmd_addr + {{(AW-1){1'b0}}, w_rd_issue};
        r_remain <= {1'b0, cmd_len} + c_ONE - {{AW{1'b0}}, w_rd_issue};
      end else if (w_wr_beat || w_rd_issue) begin
        r_addr   <= r_addr + {{(AW-1){1'b0}}, 1'b1};
        r_remain <= r_remain - c_ONE;
      end
    end
  end

  // --------------------------------------------------------------- BRAM port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      mem_we <= w_wr_beat;
      if (w_wr_beat) begin
        mem_addr <= r_addr;
        mem_din  <= wr_data;
      end else if (w_rd_issue) begin
        mem_addr <= w_issue_addr;
`ifdef BRAM_PORT_CTRL_ADDR_HOLD_EN
        mem_din  <= mem_din;
`else
        mem_din  <= '0;
`endif
      end else begin
`ifdef BRAM_PORT_CTRL_ADDR_HOLD_EN
        mem_addr <= mem_addr;
        mem_din  <= mem_din;
`else
        mem_addr <= '0;
        mem_din  <= '0;
`endif
      end
    end
  end

  // --------------------------------------------------------------- read FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_fifo_cnt <= 3'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 3'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 3'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= mem_dout;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_port_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bram_port_ctrl                                            |
// | Description : Directed self-checking bench for bram_port_ctrl with a       |
// |               registered single-port BRAM model attached.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bram_port_ctrl;

`ifdef BRAM_PORT_CTRL_ADDR_HOLD_EN
  localparam bit c_HOLD = 1'b1;
`else
  localparam bit c_HOLD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [9:0]  cmd_addr;
  logic [9:0]  cmd_len;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        busy;
  logic [9:0]  mem_addr;
  logic [15:0] mem_din;
  logic        mem_we;
  logic [15:0] mem_dout;

  logic [15:0] r_mem [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bram_port_ctrl #(.DW(16), .AW(10)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .mem_dout  (mem_dout)
  );

  // Registered single-port BRAM: read data one cycle after the address.
  always @(posedge clk) begin
    if (mem_we) r_mem[mem_addr] <= mem_din;
    mem_dout <= r_mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50 && !cmd_ready; k++) tick();
    check("idle_timeout", cmd_ready, 1);
  endtask

  task automatic do_write(input logic [9:0] a, input logic [9:0] len, input logic [15:0] d0);
    logic [9:0] last;
    check("wr_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = a; cmd_len = len;
    tick();
    cmd_valid = 1'b0;
    check("wr_ready", wr_ready, 1);
    check("wr_busy", busy, 1);
    for (int i = 0; i <= int'(len); i++) begin
      wr_valid = 1'b1;
      wr_data  = d0 + 16'(i);
      tick();
      check("wr_we", mem_we, 1);
      check("wr_addr", mem_addr, (32'(a) + i) & 32'h3FF);
      check("wr_din", mem_din, 32'(d0 + 16'(i)));
    end
    wr_valid = 1'b0;
    last = a + len;
    check("wr_back_idle", cmd_ready, 1);
    tick();
    check("wr_we_off", mem_we, 0);
    check("wr_idle_addr", mem_addr, c_HOLD ? 32'(last) : 32'd0);
  endtask

  // rd_ready held high: expects mem_addr in cycle 1, first rd_valid in cycle 3,
  // then one beat per cycle.
  task automatic do_read(input logic [9:0] a, input logic [9:0] len, input logic [15:0] d0);
    rd_ready = 1'b1;
    check("rd_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = a; cmd_len = len;
    tick();
    cmd_valid = 1'b0;
    check("rd_addr_c1", mem_addr, 32'(a));
    check("rd_valid_c1", rd_valid, 0);
    check("rd_busy", busy, 1);
    tick();
    check("rd_valid_c2", rd_valid, 0);
    tick();
    for (int i = 0; i <= int'(len); i++) begin
      check("rd_valid", rd_valid, 1);
      check("rd_data", rd_data, 32'(d0 + 16'(i)));
      tick();
    end
    check("rd_valid_end", rd_valid, 0);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [15:0] got_q [$];
    logic [31:0] exp_idle;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    rst_n = 1'b1;
    #1;
    check("rdy_before_edge", cmd_ready, 0);
    tick();
    check("rdy_after_edge", cmd_ready, 1);

    // wr_valid outside WRITE is ignored
    wr_valid = 1'b1; wr_data = 16'hFFFF;
    tick();
    check("idle_wr_ready", wr_ready, 0);
    check("idle_wr_we", mem_we, 0);
    check("idle_wr_busy", busy, 0);
    wr_valid = 1'b0;

    // Basic write then read-back
    do_write(10'h010, 10'd3, 16'hA000);
    do_read (10'h010, 10'd3, 16'hA000);

    // Back-pressure: 8-beat read with rd_ready low for 10 cycles
    do_write(10'h100, 10'd7, 16'hB000);
    rd_ready = 1'b0;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 10'h100; cmd_len = 10'd7;
    tick();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      exp_idle = c_HOLD ? 32'h103 : 32'h0;
      check("bp_addr", mem_addr, (k <= 4) ? 32'h100 + 32'(k - 1) : exp_idle);
      tick();
    end
    check("bp_full_valid", rd_valid, 1);
    check("bp_head", rd_data, 32'hB000);
    rd_ready = 1'b1;
    for (int k = 0; k < 60 && got_q.size() < 12; k++) begin
      if (rd_valid) got_q.push_back(rd_data);
      tick();
      if (cmd_ready && !rd_valid) break;
    end
    check("bp_beats", got_q.size(), 8);
    for (int i = 0; i < got_q.size(); i++) begin
      check("bp_data", got_q[i], 32'hB000 + 32'(i));
    end
    wait_idle();

    // Address wrap at the top of memory
    do_write(10'h3FE, 10'd3, 16'hC000);
    do_read (10'h3FE, 10'd3, 16'hC000);

    // Reset mid-read at beat 2 of 8
    rd_ready = 1'b1;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 10'h100; cmd_len = 10'd7;
    tick();
    cmd_valid = 1'b0;
    repeat (4) tick();
    check("pre_rst_beat2", rd_data, 32'hB002);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_mem_we", mem_we, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_busy", busy, 0);
    tick();
    check("post_rst_no_resume", rd_valid, 0);
    check("post_rst_we", mem_we, 0);
    do_read(10'h010, 10'd3, 16'hA000);

    // Single-beat read at 0x155 then idle gap
    do_write(10'h155, 10'd0, 16'hD155);
    do_read (10'h155, 10'd0, 16'hD155);
    tick();
    check("idle_gap_addr", mem_addr, c_HOLD ? 32'h155 : 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
